// File: rtl/fifo_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered read port on a single clock.
// It is the storage element behind FIFO wrappers, which own the pointers and the full/empty flags.
module fifo_ram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 8,
  parameter string SSA_EN     = "NO"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam bit BYPASS = (SSA_EN == "YES");

  // Reject parameter values that have no meaningful hardware.
  if (SSA_EN != "YES" && SSA_EN != "NO") begin : g_bad_ssa
    $error("fifo_ram: SSA_EN must be \"YES\" or \"NO\"");
  end
  if (ADDR_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_width
    $error("fifo_ram: ADDR_WIDTH and DATA_WIDTH must be at least 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  collision;

  assign collision = wr_en && rd_en && (wr_addr == rd_addr);

  // The array has no reset, so block RAM can be inferred; its contents survive a reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port. Without the bypass, a collision returns the old word (read-before-write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (BYPASS && collision) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_fifo_ram.sv
// Self-checking bench for fifo_ram: both SSA_EN modes are driven side by side from the same inputs
// and checked against constant tables, directed sequences and a behavioural memory model.
module tb_fifo_ram;

  logic        clk;
  logic        reset;
  logic [31:0] wr_data;
  logic [7:0]  wr_addr;
  logic        wr_en;
  logic [7:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_no;
  logic [31:0] rd_yes;

  int checks = 0;
  int errors = 0;

  fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .SSA_EN("NO")) dut_no (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_no)
  );

  fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .SSA_EN("YES")) dut_yes (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_yes)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic [31:0] exp_no;
    logic [31:0] exp_yes;
  } vec_t;

  vec_t vecs [9];

  // Reference model: plain array of words plus a written-yet flag per address.
  logic [31:0] ref_mem   [256];
  bit          ref_valid [256];
  logic [31:0] exp_no;
  logic [31:0] exp_yes;
  bit          known_no;
  bit          known_yes;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_both(input string name, input logic [31:0] expected);
    check_output({name, " ssa=NO"}, rd_no, expected);
    check_output({name, " ssa=YES"}, rd_yes, expected);
  endtask

  task automatic check_model(input string name);
    if (known_no)  check_output({name, " ssa=NO"}, rd_no, exp_no);
    if (known_yes) check_output({name, " ssa=YES"}, rd_yes, exp_yes);
  endtask

  // Drive one clock cycle outside reset and advance the model; returns 1 time unit after the edge.
  task automatic apply_stimulus(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                                input logic re, input logic [7:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    if (re) begin
      known_no = ref_valid[ra];
      exp_no   = ref_mem[ra];
      if (we && wa == ra) begin
        known_yes = 1'b1;
        exp_yes   = wd;
      end else begin
        known_yes = ref_valid[ra];
        exp_yes   = ref_mem[ra];
      end
    end
    if (we) begin
      ref_mem[wa]   = wd;
      ref_valid[wa] = 1'b1;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [31:0] q [$];
    logic [31:0] wd;
    logic [31:0] expv;

    vecs[0] = '{1'b1, 8'd7,   32'h11111111, 1'b0, 8'd0,   32'h00000000, 32'h00000000};
    vecs[1] = '{1'b1, 8'd3,   32'h12345678, 1'b0, 8'd0,   32'h00000000, 32'h00000000};
    vecs[2] = '{1'b0, 8'd0,   32'h00000000, 1'b1, 8'd3,   32'h12345678, 32'h12345678};
    vecs[3] = '{1'b1, 8'd7,   32'h22222222, 1'b1, 8'd7,   32'h11111111, 32'h22222222};
    vecs[4] = '{1'b0, 8'd0,   32'h00000000, 1'b1, 8'd7,   32'h22222222, 32'h22222222};
    vecs[5] = '{1'b1, 8'd8,   32'h0000AAAA, 1'b1, 8'd3,   32'h12345678, 32'h12345678};
    vecs[6] = '{1'b0, 8'd0,   32'h00000000, 1'b1, 8'd8,   32'h0000AAAA, 32'h0000AAAA};
    vecs[7] = '{1'b1, 8'd255, 32'hDEADBEEF, 1'b0, 8'd0,   32'h0000AAAA, 32'h0000AAAA};
    vecs[8] = '{1'b0, 8'd0,   32'h00000000, 1'b1, 8'd255, 32'hDEADBEEF, 32'hDEADBEEF};

    reset   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    known_no  = 1'b1;
    known_yes = 1'b1;
    exp_no    = '0;
    exp_yes   = '0;

    #2 reset = 1'b1;
    #1 check_both("reset async", 32'h0);
    @(posedge clk);
    #1 check_both("reset held", 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      check_output($sformatf("vec%0d ssa=NO", i), rd_no, vecs[i].exp_no);
      check_output($sformatf("vec%0d ssa=YES", i), rd_yes, vecs[i].exp_yes);
    end

    // Hold: rd_data must not move while rd_en is low, even as the read address is overwritten.
    apply_stimulus(1'b1, 8'd3, 32'h12345678, 1'b0, 8'd0);
    apply_stimulus(1'b0, 8'd0, 32'h0, 1'b1, 8'd3);
    check_both("hold read", 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 8'd3, 32'hFFFFFFFF, 1'b0, 8'd0);
      check_both($sformatf("hold cycle%0d", i), 32'h12345678);
    end
    apply_stimulus(1'b0, 8'd0, 32'h0, 1'b1, 8'd3);
    check_both("hold after", 32'hFFFFFFFF);

    // Mid-stream reset: output clears at once, strobes are ignored, memory survives.
    apply_stimulus(1'b1, 8'd0, 32'h0BADF00D, 1'b0, 8'd0);
    apply_stimulus(1'b0, 8'd0, 32'h0, 1'b1, 8'd0);
    check_both("pre-reset read", 32'h0BADF00D);
    #3 reset = 1'b1;
    #1 check_both("mid-cycle reset", 32'h0);
    wr_en   = 1'b1;
    wr_addr = 8'd0;
    wr_data = 32'h55555555;
    rd_en   = 1'b1;
    rd_addr = 8'd0;
    @(posedge clk);
    #1 check_both("strobes in reset", 32'h0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b0;
    exp_no  = '0;
    exp_yes = '0;
    apply_stimulus(1'b0, 8'd0, 32'h0, 1'b1, 8'd0);
    check_both("post-reset read", 32'h0BADF00D);

    // Fill every address, then read it all back.
    for (int a = 0; a < 256; a++) apply_stimulus(1'b1, 8'(a), 32'hA5A50000 + 32'(a), 1'b0, 8'd0);
    for (int a = 0; a < 256; a++) begin
      apply_stimulus(1'b0, 8'd0, 32'h0, 1'b1, 8'(a));
      check_both($sformatf("fill addr%0d", a), 32'hA5A50000 + 32'(a));
    end

    // Wrap: 300 writes through a free-running 8-bit pointer.
    for (int n = 0; n < 300; n++) apply_stimulus(1'b1, 8'(n), 32'(n), 1'b0, 8'd0);
    for (int a = 0; a < 256; a++) begin
      apply_stimulus(1'b0, 8'd0, 32'h0, 1'b1, 8'(a));
      check_both($sformatf("wrap addr%0d", a), (a < 44) ? 32'(256 + a) : 32'(a));
    end

    // Streaming: write leads read by two addresses, so each read sees the word from two cycles back.
    for (int i = 0; i < 2; i++) begin
      wd = $urandom;
      apply_stimulus(1'b1, 8'(i), wd, 1'b0, 8'd0);
      q.push_back(wd);
    end
    for (int k = 0; k < 1000; k++) begin
      wd = $urandom;
      apply_stimulus(1'b1, 8'(k + 2), wd, 1'b1, 8'(k));
      expv = q.pop_front();
      q.push_back(wd);
      check_both($sformatf("stream%0d", k), expv);
    end

    // Random traffic over a small address window to provoke plenty of collisions.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                     1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
      check_model($sformatf("random%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
